// File: rtl/fetch_unit_pkg.sv
// Shared parameters, state encoding and address helper
// for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int ADDRESS_BUS_WIDTH = 11;
    localparam int INSTRUCTION_WIDTH = 33;
    localparam int NUM_ADDRESS       = 2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Sequential fetch address with wrap at the top of memory.
    function automatic logic [ADDRESS_BUS_WIDTH-1:0] next_pc(
        input logic [ADDRESS_BUS_WIDTH-1:0] pc
    );
        if (pc == ADDRESS_BUS_WIDTH'(NUM_ADDRESS - 1))
            return '0;
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {instruction, pc} entries.
// Head is visible combinationally; flush empties it in one cycle.
module fetch_buffer #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    // Storage write; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues reads to IRAM, buffers tagged
// responses and hands them to decode over a valid/ready pair.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int RESET_PC  = 1024,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         halt_req,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
    output logic [ADDRESS_BUS_WIDTH-1:0] iram_addr,
    output logic                         iram_rnw,
    input  logic [INSTRUCTION_WIDTH-1:0] iram_data,
    output logic                         instr_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc,
    input  logic                         instr_ready,
    output logic                         busy
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;
    localparam int EW = IW + AW;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_e   state;
    fetch_state_e   state_next;
    logic [AW-1:0]  fetch_pc;
    logic           in_flight;
    logic [CW-1:0]  count;
    logic           empty;
    logic [EW-1:0]  head;
    logic [OW-1:0]  occupancy;
    logic           issue;
    logic           push;
    logic           pop;
    logic           flush;

    assign occupancy = OW'(count) + OW'(in_flight);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state and per-cycle control; redirect overrides all else.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                end else begin
                    push = in_flight;
                    pop  = instr_valid && instr_ready;
                    if (halt_req)
                        state_next = ST_DRAIN;
                    else
                        issue = occupancy < OW'(BUF_DEPTH);
                end
            end
            ST_DRAIN: begin
                push = in_flight;
                pop  = instr_valid && instr_ready;
                if (empty && !in_flight)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Fetch pointer, memory address and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= AW'(RESET_PC);
            iram_addr <= '0;
            in_flight <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            fetch_pc  <= AW'(RESET_PC);
            in_flight <= 1'b0;
        end else if (flush) begin
            fetch_pc  <= redirect_pc;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                iram_addr <= fetch_pc;
                fetch_pc  <= next_pc(fetch_pc);
            end
        end
    end

    fetch_buffer #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({iram_data, iram_addr}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    assign instr_valid = !empty;
    assign instr       = instr_valid ? head[EW-1:AW] : '0;
    assign instr_pc    = instr_valid ? head[AW-1:0] : '0;
    assign iram_rnw    = 1'b1;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus random traffic
// checked against an expected-address stream model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          halt_req;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] iram_addr;
    logic          iram_rnw;
    logic [IW-1:0] iram_data;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          busy;

    logic          start_w;
    logic          halt_w;
    logic [AW-1:0] iram_addr_w;
    logic          iram_rnw_w;
    logic [IW-1:0] iram_data_w;
    logic          instr_valid_w;
    logic [IW-1:0] instr_w;
    logic [AW-1:0] instr_pc_w;
    logic          busy_w;

    logic [IW-1:0] mem [NUM_ADDRESS];

    int            n_checks;
    int            n_errors;
    int            n_acc;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] last_pc;
    logic          running;
    logic          held;
    logic [AW-1:0] held_pc;
    logic [IW-1:0] held_instr;

    assign iram_data   = mem[iram_addr];
    assign iram_data_w = mem[iram_addr_w];

    fetch_unit #(.RESET_PC(1024), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .iram_addr      (iram_addr),
        .iram_rnw       (iram_rnw),
        .iram_data      (iram_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .busy           (busy)
    );

    fetch_unit #(.RESET_PC(NUM_ADDRESS - 1), .BUF_DEPTH(DEPTH)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_w),
        .halt_req       (halt_w),
        .redirect_valid (1'b0),
        .redirect_pc    ('0),
        .iram_addr      (iram_addr_w),
        .iram_rnw       (iram_rnw_w),
        .iram_data      (iram_data_w),
        .instr_valid    (instr_valid_w),
        .instr          (instr_w),
        .instr_pc       (instr_pc_w),
        .instr_ready    (1'b1),
        .busy           (busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: model the handshake, then advance the clock.
    task automatic run_cycle(input logic rdy);
        logic redir;
        redir = redirect_valid && running;
        instr_ready = rdy;
        if (held) begin
            check("hold_valid", instr_valid, 1'b1);
            check("hold_pc", instr_pc, held_pc);
            check("hold_instr", instr, held_instr);
        end
        held = 1'b0;
        if (instr_valid && !redir) begin
            if (rdy) begin
                check("acc_pc", instr_pc, exp_pc);
                check("acc_instr", instr, mem[exp_pc]);
                last_pc = instr_pc;
                exp_pc  = AW'((int'(exp_pc) + 1) % NUM_ADDRESS);
                n_acc++;
            end else begin
                held       = 1'b1;
                held_pc    = instr_pc;
                held_instr = instr;
            end
        end
        if (redir)
            exp_pc = redirect_pc;
        tick();
    endtask

    task automatic wait_acc(input int target);
        for (int i = 0; i < 40 && n_acc < target; i++)
            run_cycle(1'b1);
        check("acc_count", 64'(n_acc >= target), 64'd1);
    endtask

    task automatic begin_run();
        exp_pc  = AW'(1024);
        running = 1'b1;
        start   = 1'b1;
        run_cycle(1'b1);
        start   = 1'b0;
    endtask

    task automatic drain();
        redirect_valid = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b1;
        run_cycle(1'b1);
        halt_req = 1'b0;
        running  = 1'b0;
        for (int i = 0; i < 20 && busy; i++)
            run_cycle(1'b1);
        check("drain_busy", busy, 1'b0);
        check("drain_valid", instr_valid, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] wexp [3];
        logic [AW-1:0] addr_h;
        logic          rdy;
        int            base;
        int            k;

        n_checks = 0;
        n_errors = 0;
        n_acc    = 0;
        held     = 1'b0;
        running  = 1'b0;
        exp_pc   = '0;
        last_pc  = '0;
        held_pc  = '0;
        held_instr = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        start_w  = 1'b0;
        halt_w   = 1'b0;
        for (int i = 0; i < NUM_ADDRESS; i++)
            mem[i] = {1'($urandom), 32'($urandom)};
        mem[1024] = 33'h011000010;
        mem[1025] = 33'h012000020;
        mem[1026] = 33'h052210000;
        mem[1027] = 33'h032000030;

        repeat (2) tick();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, '0);
        check("rst_pc", instr_pc, '0);
        check("rst_addr", iram_addr, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_rnw", iram_rnw, 1'b1);
        check("rst_busy_w", busy_w, 1'b0);
        rst_n = 1'b1;
        tick();

        // Straight-line program with decode always ready.
        begin_run();
        check("lat_e0", instr_valid, 1'b0);
        run_cycle(1'b1);
        check("lat_e1", instr_valid, 1'b0);
        run_cycle(1'b1);
        check("lat_e2", instr_valid, 1'b1);
        check("first_pc", instr_pc, 1024);
        wait_acc(4);
        drain();

        // Decode stalls five cycles; outstanding reads bounded.
        begin_run();
        repeat (5) run_cycle(1'b0);
        check("stall_addr", iram_addr, 1025);
        check("stall_pc", instr_pc, 1024);
        check("stall_instr", instr, 33'h011000010);
        base = n_acc;
        wait_acc(base + 4);
        drain();

        // Redirect in IDLE has no effect.
        redirect_valid = 1'b1;
        redirect_pc    = AW'(5);
        run_cycle(1'b1);
        redirect_valid = 1'b0;
        check("idle_redir_busy", busy, 1'b0);
        check("idle_redir_valid", instr_valid, 1'b0);

        // Redirect to 1026 while 1025 is in flight.
        begin_run();
        for (int i = 0; i < 10 && iram_addr != AW'(1025); i++)
            run_cycle(1'b1);
        check("redir_setup", iram_addr, 1025);
        redirect_valid = 1'b1;
        redirect_pc    = AW'(1026);
        run_cycle(1'b1);
        redirect_valid = 1'b0;
        base = n_acc;
        wait_acc(base + 1);
        check("redir_pc", last_pc, 1026);
        wait_acc(base + 2);
        drain();

        // Halt after two accepted instructions.
        begin_run();
        base = n_acc;
        wait_acc(base + 2);
        addr_h = iram_addr;
        base = n_acc;
        drain();
        check("halt_noissue", iram_addr, addr_h);
        check("halt_outstanding", 64'((n_acc - base) <= DEPTH), 64'd1);

        // Reset with a full buffer.
        begin_run();
        repeat (5) run_cycle(1'b0);
        check("full_valid", instr_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", instr_valid, 1'b0);
        check("arst_instr", instr, '0);
        check("arst_pc", instr_pc, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_addr", iram_addr, '0);
        tick();
        rst_n   = 1'b1;
        held    = 1'b0;
        running = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1);
            check("post_rst_valid", instr_valid, 1'b0);
        end
        check("post_rst_busy", busy, 1'b0);
        begin_run();
        base = n_acc;
        wait_acc(base + 2);
        drain();

        // Fetch across the top-of-memory wrap.
        wexp[0] = AW'(NUM_ADDRESS - 1);
        wexp[1] = '0;
        wexp[2] = AW'(1);
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            tick();
            if (instr_valid_w) begin
                check("wrap_pc", instr_pc_w, wexp[k]);
                check("wrap_instr", instr_w, mem[wexp[k]]);
                k++;
            end
        end
        check("wrap_count", 64'(k), 64'd3);
        halt_w = 1'b1;
        tick();
        halt_w = 1'b0;
        for (int i = 0; i < 20 && busy_w; i++)
            tick();
        check("wrap_busy", busy_w, 1'b0);

        // Random traffic: stalls, redirects, stray starts.
        for (int s = 0; s < 6; s++) begin
            begin_run();
            for (int c = 0; c < 80; c++) begin
                rdy = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 99) < 6) begin
                    redirect_valid = 1'b1;
                    if ($urandom_range(0, 3) == 0)
                        redirect_pc = AW'(NUM_ADDRESS - 2);
                    else
                        redirect_pc = AW'($urandom_range(0, NUM_ADDRESS - 1));
                end
                start = ($urandom_range(0, 99) < 5);
                run_cycle(rdy);
                redirect_valid = 1'b0;
                start = 1'b0;
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 1024, SHALL set the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL set the instruction buffer depth in entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL begin fetching from RESET_PC when sampled high in IDLE.
REQ-006 halt_req  input  1  SHALL stop new fetches and drain outstanding ones.
REQ-007 redirect_valid  input  1  SHALL request a fetch-stream restart at redirect_pc.
REQ-008 redirect_pc  input  ADDRESS_BUS_WIDTH  SHALL give the new fetch address.
REQ-009 iram_addr  output  ADDRESS_BUS_WIDTH  SHALL drive the instruction memory address.
REQ-010 iram_rnw  output  1  SHALL drive instruction memory read_not_write; constant 1.
REQ-011 iram_data  input  INSTRUCTION_WIDTH  SHALL carry memory read data, valid one cycle after the address is issued.
REQ-012 instr_valid  output  1  SHALL flag that instr and instr_pc hold a valid fetched instruction.
REQ-013 instr  output  INSTRUCTION_WIDTH  SHALL be the instruction word presented to decode.
REQ-014 instr_pc  output  ADDRESS_BUS_WIDTH  SHALL be the address instr was fetched from.
REQ-015 instr_ready  input  1  SHALL indicate decode accepts instr this cycle.
REQ-016 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on halt_req; DRAIN->IDLE when buffer empty and no read in flight.
REQ-018 In RUN the block SHALL issue a read (fetch_pc on iram_addr, in-flight flag set) only when buffer occupancy plus in-flight count is less than BUF_DEPTH.
REQ-019 On each issued read, fetch_pc SHALL advance by 1, wrapping from NUM_ADDRESS-1 to 0.
REQ-020 The response SHALL be written into the buffer, tagged with its address, in the cycle after issue; latency start-to-first-instr_valid is 2 cycles.
REQ-021 Buffer SHALL be FIFO; head drives instr/instr_pc; transfer occurs when instr_valid and instr_ready are both high.
REQ-022 instr and instr_pc SHALL stay stable while instr_valid is high and instr_ready is low.
REQ-023 Simultaneous push and pop on a full buffer SHALL be legal and preserve order; the buffer SHALL never overflow.
REQ-024 redirect_valid in RUN SHALL, in that cycle, flush the buffer, squash any in-flight response, and set fetch_pc to redirect_pc; the next issue occurs the following cycle.
REQ-025 redirect_valid SHALL take priority over issue, push, pop and halt_req in the same cycle.
REQ-026 redirect_valid in IDLE or DRAIN SHALL be ignored.
REQ-027 With no issue, iram_addr SHALL hold its last value.
REQ-028 start while not in IDLE SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, fetch_pc RESET_PC, buffer empty, in-flight cleared, instr_valid 0, instr 0, instr_pc 0, iram_addr 0, busy 0, iram_rnw 1.
REQ-030 Reset asserted mid-fetch SHALL discard all in-flight and buffered instructions; no instr_valid follows deassertion until a new start.

Structure
REQ-031 ADDRESS_BUS_WIDTH, INSTRUCTION_WIDTH, NUM_ADDRESS SHALL come from the shared params include; state encodings SHALL live there too.
REQ-032 The buffer SHALL be a sub-module fetch_buffer (synchronous FIFO, width INSTRUCTION_WIDTH+ADDRESS_BUS_WIDTH, depth BUF_DEPTH).

Verification
REQ-033 Memory[1024..1027] = 33'h011000010, 33'h012000020, 33'h052210000, 33'h032000030; start, instr_ready held 1 -> those words at instr_pc 1024..1027 in order, first instr_valid 2 cycles after start.
REQ-034 Same program, instr_ready 0 for 5 cycles -> occupancy plus in-flight never exceeds 2, instr held at 33'h011000010, no word lost or duplicated after release.
REQ-035 redirect_valid with redirect_pc 1026 while the read of 1025 is in flight -> 1025 never presented; next instr_pc is 1026.
REQ-036 RESET_PC = NUM_ADDRESS-1, start -> instr_pc sequence NUM_ADDRESS-1, 0, 1.
REQ-037 halt_req after 2 instructions accepted -> outstanding fetches delivered, no new issue, busy falls once drained.
REQ-038 rst_n pulsed low with buffer full -> instr_valid 0 immediately; it stays 0 until the next start.
